// File: rtl/countone_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countone_mul_pkg
//  Description : Shared constants and helper functions for the countone
//                multiply / multiply-accumulate pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package countone_mul_pkg;

    localparam int unsigned c_def_a_width   = 12;
    localparam int unsigned c_def_b_width   = 12;
    localparam int unsigned c_def_acc_width = 32;
    localparam int unsigned c_def_num_stage = 4;

    // Widest datapath the helper functions handle.
    localparam int unsigned c_max_w = 128;

    // Zero- or sign-extend the low 'width' bits of val to the full c_max_w.
    function automatic logic [c_max_w-1:0] extend(
        input logic [c_max_w-1:0] val,
        input int unsigned        width,
        input logic               is_signed
    );
        logic [c_max_w-1:0] upper_mask;
        logic [c_max_w-1:0] shifted;
        logic               msb;
        upper_mask = {c_max_w{1'b1}} << width;
        shifted    = val >> (width - 1);
        msb        = shifted[0] & is_signed;
        return (val & ~upper_mask) | (msb ? upper_mask : '0);
    endfunction

    // Overflow of an add: carry-out when unsigned, sign disagreement when signed.
    function automatic logic ovf_detect(
        input logic is_signed,
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb,
        input logic carry
    );
        if (is_signed) begin
            return (a_msb == b_msb) && (sum_msb != a_msb);
        end
        return carry;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countone_mul_core.sv
`default_nettype none
// ============================================================================
//  Module      : countone_mul_core
//  Description : NUM_STAGE-1 deep multiplier pipe. Stage 1 registers the
//                operands and sideband; later stages carry the full product.
//  Revision    : 1.0 - initial release
// ============================================================================
module countone_mul_core
    import countone_mul_pkg::*;
#(
    parameter int unsigned A_WIDTH   = c_def_a_width,
    parameter int unsigned B_WIDTH   = c_def_b_width,
    parameter int unsigned NUM_STAGE = c_def_num_stage,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_ce,
    input  logic                       i_in_valid,
    input  logic [A_WIDTH-1:0]         i_din0,
    input  logic [B_WIDTH-1:0]         i_din1,
    input  logic                       i_acc_en,
    input  logic                       i_acc_clr,
    output logic                       o_valid,
    output logic                       o_acc_en,
    output logic                       o_acc_clr,
    output logic [A_WIDTH+B_WIDTH-1:0] o_prod
);

    localparam int unsigned c_depth  = NUM_STAGE - 1;
    localparam int unsigned c_prod_w = A_WIDTH + B_WIDTH;

    logic [A_WIDTH-1:0]  r_a_q,   w_a_d;
    logic [B_WIDTH-1:0]  r_b_q,   w_b_d;
    // Sideband shift registers: bit 0 is stage 1, bit c_depth-1 the last stage.
    logic [c_depth-1:0]  r_vld_q, w_vld_d;
    logic [c_depth-1:0]  r_en_q,  w_en_d;
    logic [c_depth-1:0]  r_clr_q, w_clr_d;

    logic [c_prod_w-1:0] w_a_ext;
    logic [c_prod_w-1:0] w_b_ext;
    logic [c_prod_w-1:0] w_prod;

    // The low c_prod_w bits of a product of extended operands are exact for
    // both signed and unsigned interpretation, so one multiplier serves both.
    assign w_a_ext = {{B_WIDTH{r_a_q[A_WIDTH-1] & SIGNED}}, r_a_q};
    assign w_b_ext = {{A_WIDTH{r_b_q[B_WIDTH-1] & SIGNED}}, r_b_q};
    assign w_prod  = w_a_ext * w_b_ext;

    // Next state of the operand stage and the sideband shift registers.
    always_comb begin
        w_a_d   = r_a_q;
        w_b_d   = r_b_q;
        w_vld_d = r_vld_q;
        w_en_d  = r_en_q;
        w_clr_d = r_clr_q;
        if (i_ce) begin
            w_a_d   = i_din0;
            w_b_d   = i_din1;
            w_vld_d = (r_vld_q << 1) | c_depth'(i_in_valid);
            w_en_d  = (r_en_q  << 1) | c_depth'(i_acc_en);
            w_clr_d = (r_clr_q << 1) | c_depth'(i_acc_clr);
        end
    end

    // Operand and sideband registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_vld_q <= '0;
            r_en_q  <= '0;
            r_clr_q <= '0;
        end else begin
            r_a_q   <= w_a_d;
            r_b_q   <= w_b_d;
            r_vld_q <= w_vld_d;
            r_en_q  <= w_en_d;
            r_clr_q <= w_clr_d;
        end
    end

    assign o_valid   = r_vld_q[c_depth-1];
    assign o_acc_en  = r_en_q[c_depth-1];
    assign o_acc_clr = r_clr_q[c_depth-1];

    if (NUM_STAGE == 2) begin : g_no_prod_pipe
        // Shortest pipe: the product feeds the accumulate stage directly.
        assign o_prod = w_prod;
    end else begin : g_prod_pipe
        localparam int unsigned c_pw_all = (c_depth - 1) * c_prod_w;

        // Flattened product stages; the lowest slice is stage 2.
        logic [c_pw_all-1:0] r_prod_q, w_prod_d;

        // Shift a new product in on every enabled cycle.
        always_comb begin
            w_prod_d = r_prod_q;
            if (i_ce) begin
                w_prod_d = (r_prod_q << c_prod_w) | c_pw_all'(w_prod);
            end
        end

        // Product pipeline registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prod_q <= '0;
            end else begin
                r_prod_q <= w_prod_d;
            end
        end

        assign o_prod = r_prod_q[c_pw_all-1 -: c_prod_w];
    end

endmodule
`default_nettype wire

// File: rtl/countone_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : countone_mac_pipe
//  Description : Pipelined multiplier / multiply-accumulate with valid
//                tracking, global clock enable and sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module countone_mac_pipe
    import countone_mul_pkg::*;
#(
    parameter int unsigned A_WIDTH   = c_def_a_width,
    parameter int unsigned B_WIDTH   = c_def_b_width,
    parameter int unsigned ACC_WIDTH = c_def_acc_width,
    parameter int unsigned NUM_STAGE = c_def_num_stage,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] dout,
    output logic                 ovf
);

    localparam int unsigned c_prod_w = A_WIDTH + B_WIDTH;

    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_err_acc_narrow
        $error("countone_mac_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
    end
    if (ACC_WIDTH > c_max_w) begin : g_err_acc_wide
        $error("countone_mac_pipe: ACC_WIDTH exceeds supported maximum");
    end
    if (NUM_STAGE < 2) begin : g_err_num_stage
        $error("countone_mac_pipe: NUM_STAGE must be >= 2");
    end

    logic                 w_core_valid;
    logic                 w_core_en;
    logic                 w_core_clr;
    logic [c_prod_w-1:0]  w_core_prod;

    countone_mul_core #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .NUM_STAGE (NUM_STAGE),
        .SIGNED    (SIGNED)
    ) u_core (
        .clk        (clk),
        .rst        (reset),
        .i_ce       (ce),
        .i_in_valid (in_valid),
        .i_din0     (din0),
        .i_din1     (din1),
        .i_acc_en   (acc_en),
        .i_acc_clr  (acc_clr),
        .o_valid    (w_core_valid),
        .o_acc_en   (w_core_en),
        .o_acc_clr  (w_core_clr),
        .o_prod     (w_core_prod)
    );

    logic [ACC_WIDTH-1:0] r_acc_q,       w_acc_d;
    logic [ACC_WIDTH-1:0] r_dout_q,      w_dout_d;
    logic                 r_ovf_q,       w_ovf_d;
    logic                 r_out_valid_q, w_out_valid_d;

    logic [c_max_w-1:0]   w_ext_full;
    logic [ACC_WIDTH-1:0] w_prod_ext;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_carry;
    logic                 w_ovf_hit;

    assign w_ext_full = extend(c_max_w'(w_core_prod), c_prod_w, SIGNED);
    assign w_prod_ext = w_ext_full[ACC_WIDTH-1:0];

    // A clearing operand adds against zero, so it can never flag overflow.
    assign w_base           = w_core_clr ? '0 : r_acc_q;
    assign {w_carry, w_sum} = {1'b0, w_base} + {1'b0, w_prod_ext};
    assign w_ovf_hit        = ovf_detect(SIGNED, w_base[ACC_WIDTH-1],
                                         w_prod_ext[ACC_WIDTH-1],
                                         w_sum[ACC_WIDTH-1], w_carry);

    // Accumulate / pass-through stage; only a valid slot changes state.
    always_comb begin
        w_acc_d       = r_acc_q;
        w_dout_d      = r_dout_q;
        w_ovf_d       = r_ovf_q;
        w_out_valid_d = r_out_valid_q;
        if (ce) begin
            w_out_valid_d = w_core_valid;
            if (w_core_valid) begin
                if (w_core_en) begin
                    w_acc_d  = w_sum;
                    w_dout_d = w_sum;
                    w_ovf_d  = (r_ovf_q & ~w_core_clr) | w_ovf_hit;
                end else begin
                    w_dout_d = w_prod_ext;
                end
            end
        end
    end

    // Final stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_q       <= '0;
            r_dout_q      <= '0;
            r_ovf_q       <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_acc_q       <= w_acc_d;
            r_dout_q      <= w_dout_d;
            r_ovf_q       <= w_ovf_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign dout      = r_dout_q;
    assign ovf       = r_ovf_q;

endmodule
`default_nettype wire

// File: doc/countone_mac_pipe.md
# countone_mac_pipe

Parametrised pipelined multiply / multiply-accumulate unit for the countone datapath. It generalises the fixed 12×12 unsigned multiplier with configurable operand widths, signedness and pipeline depth. It also adds valid tracking through the pipe and an optional accumulator with sticky overflow. It sits between the HLS-generated control logic and the result registers and serves as a drop-in multiplier, or as a MAC when `acc_en` is driven.

## Interface
- `A_WIDTH`, 12: width of `din0`.
- `B_WIDTH`, 12: width of `din1`.
- `ACC_WIDTH`, 32: width of `dout` and of the accumulator. Must be ≥ `A_WIDTH + B_WIDTH`; elaboration error otherwise.
- `NUM_STAGE`, 4: total latency in enabled cycles. Must be ≥ 2.
- `SIGNED`, 0: 0 treats both operands as unsigned; 1 treats both as two's complement.

- `clk` in 1: sole clock; all registers update on its rising edge.
- `reset` in 1: asynchronous, active-high; clears every register.
- `ce` in 1: global clock enable; 0 freezes the entire pipe.
- `in_valid` in 1: operands on `din0`/`din1` are valid this cycle.
- `din0` in `A_WIDTH`: operand A.
- `din1` in `B_WIDTH`: operand B.
- `acc_en` in 1: 1 adds the product to the accumulator; 0 passes the product through.
- `acc_clr` in 1: with `acc_en`, the accumulator restarts from 0 for this operand.
- `out_valid` out 1: `dout` carries a new result this cycle.
- `dout` out `ACC_WIDTH`: result, either the product or the accumulator value.
- `ovf` out 1: sticky accumulator overflow flag.

## Operation
- An operand is accepted on a rising edge when `ce`=1 and `in_valid`=1.
- `acc_en` and `acc_clr` are sampled with the operand and travel down the pipe alongside it.
- Stage 1 registers the operands, `in_valid` and the flags.
- Stages 2 to `NUM_STAGE-1` compute and carry the full `A_WIDTH+B_WIDTH` product.
  - The product is unsigned, or signed when `SIGNED`=1.
  - It is then zero- or sign-extended to `ACC_WIDTH` per `SIGNED`.
- The final stage acts only when the valid bit in that slot is 1:
  - `acc_en`=0: `dout` = extended product; the accumulator and `ovf` are unchanged.
  - `acc_en`=1, `acc_clr`=0: accumulator = accumulator + product, modulo 2^`ACC_WIDTH`; `dout` = new accumulator.
  - `acc_en`=1, `acc_clr`=1: accumulator = product; `ovf` is cleared, then updated by this add against a zero base (so it stays 0).
- Overflow detection:
  - Unsigned: carry out of bit `ACC_WIDTH-1`.
  - Signed: both addends have the same sign and the result sign differs.
  - A detected overflow sets `ovf` to 1. It stays 1 until an `acc_clr` operand retires or `reset` is asserted.
- Bubbles (`in_valid`=0) propagate as empty slots. They never touch the accumulator, `dout` or `ovf`.
- `dout` holds its last value while `out_valid`=0.

## Timing
- Reset values: `out_valid`=0, `dout`=0, `ovf`=0, accumulator=0, all valid bits=0. Reset takes effect immediately, independent of `ce` and `clk`.
- Latency: an operand accepted at enabled edge N drives `out_valid`=1 immediately after enabled edge N+`NUM_STAGE`-1.
  - This is `NUM_STAGE` cycles counted from the presentation of the inputs.
  - Edges with `ce`=0 do not count toward latency.
- Throughput: one operand per enabled cycle, including back-to-back accumulates. There is no hazard because the add happens in the single final stage.
- `out_valid` is a one-cycle pulse per result when `ce` stays 1. While `ce`=0, `out_valid`, `dout` and `ovf` hold.
- Reset mid-operation: all in-flight operands are discarded. No result for them appears after `reset` deasserts.

## Structure
- Package `countone_mul_pkg` holds:
  - default width and stage constants;
  - an `extend` function implementing zero/sign extension selected by `SIGNED`;
  - an overflow-detect function.
- Sub-module `countone_mul_core` implements the `NUM_STAGE-1`-deep multiplier pipe with a valid/flag sideband.
- The top level adds the accumulate stage, the `ovf` logic and the parameter checks.

## Test plan
- Defaults, `acc_en`=0, `din0`=4095, `din1`=4095: `out_valid` appears 4 cycles later with `dout`=16769025 (0xFFE001) and `ovf`=0.
- Stall: issue 3×5, then drop `ce` for 3 cycles after the second edge. `out_valid` fires on cycle 7 with `dout`=15, and outputs stay frozen during the stall.
- Accumulate back-to-back: (3,4,`acc_clr`=1), (5,6), (7,8), all `acc_en`=1. `dout` sequence is 12, 42, 98 on consecutive cycles.
- `SIGNED`=1: `din0`=12'hFFF, `din1`=12'h002, `acc_en`=0 gives `dout`=0xFFFFFFFE. Accumulating (-1)×2 twice from clear gives 0xFFFFFFFC, `ovf`=0.
- `ACC_WIDTH`=24, unsigned: accumulate 4095×4095 twice from clear. `dout`=16760834 (wrapped) and `ovf`=1. `ovf` stays 1 over bubbles and clears when the next `acc_clr` operand retires.
- Assert `reset` with 3 operands in flight: `out_valid`, `dout` and `ovf` go to 0 before the next edge. No `out_valid` appears for those operands after release.
